ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Front-end stage that turns the raw PS/2 keyboard clock/data lines into the 11-bit toggle-strobed `ps2_key` event word consumed by the Spectrum keyboard-matrix block. It synchronises and deglitches the lines and deserialises 11-bit PS/2 frames with parity and stop checks. It folds the `E0` (extended), `F0` (release) and `E1` (Pause) prefixes into a single event per key, and presents each event by toggling bit 10.

## Interface
Parameters:
- `FILTER`, default 8: consecutive identical samples required before the filtered PS/2 clock changes level.
- `TIMEOUT`, default 100000: idle `clk_sys` cycles inside a frame before the frame is aborted (~2 ms at 50 MHz).

Ports:
- `clk_sys`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock from the pad; asynchronous.
- `ps2_data`  in  1  raw PS/2 data from the pad; asynchronous.
- `ps2_key`  out  11  event word:
  - [10] toggles once per event.
  - [9] 1 = press, 0 = release.
  - [8] extended (`E0`) flag.
  - [7:0] scancode.
- `err`  out  1  one-cycle pulse when a frame is rejected (parity, stop or timeout).

## Operation
- Input conditioning:
  - Both inputs pass through a 2-FF synchroniser.
  - Synchronised clock feeds a filter counter. The filtered clock `fclk` takes the new level only after `FILTER` consecutive equal samples.
  - A falling edge is `fclk` going 1→0. Data is sampled from the synchronised `ps2_data` on that cycle.
- Frame FSM:
  - `IDLE`: on a falling edge with data=0 (start bit), go to `DATA` with bit count 0. Data=1 is ignored.
  - `DATA`: shift data in LSB first. After 8 bits go to `PARITY`.
  - `PARITY`: capture the bit. Odd parity is required (XOR of the 8 data bits and parity = 1). Go to `STOP`.
  - `STOP`:
    - If stop=1 and parity is good, the byte is valid and goes to the byte handler.
    - Otherwise pulse `err`, clear all prefix state and discard the byte.
    - Return to `IDLE` in both cases.
- Timeout:
  - Applies in any state other than `IDLE`.
  - The counter resets on every falling edge.
  - Reaching `TIMEOUT` cycles: go to `IDLE`, pulse `err`, clear prefix state.
- Byte handler (valid bytes only):
  - `skip` counter non-zero: decrement, no event.
  - `E1`: set `skip`=7, no event. Pause is dropped entirely.
  - `E0`: set the `ext` flag.
  - `F0`: set the `rel` flag.
  - Any other byte: `ps2_key` ← {~`ps2_key`[10], ~`rel`, `ext`, byte}, then clear `ext` and `rel`.
- `E0` and `F0` may arrive in either order; both flags persist until the next code byte.
- A frame in progress during reset is lost. No partial byte is ever emitted.

## Timing
- Reset values: `ps2_key`=11'h000, `err`=0, FSM=`IDLE`, `ext`=`rel`=0, `skip`=0, filter counter=0, `fclk`=1.
- Latency from a raw `ps2_clk` falling edge to the registered bit: 2 (sync) + `FILTER` cycles. Deglitch is symmetric on rising edges.
- `ps2_key` updates on the cycle after the stop-bit falling edge is detected and holds until the next event.
- `err` is high for exactly one cycle per rejected frame. A timeout and a frame rejection are never reported in the same cycle.
- Prefix bytes never alter `ps2_key`.
- Pulses on `ps2_clk` shorter than `FILTER` cycles produce no edge.
- Minimum supported PS/2 clock half-period is ≥ `FILTER`+4 cycles.

## Test plan
- Reset, then a frame of byte 8'h1C (A) with parity 0 and stop 1 → `ps2_key`=11'h61C (bit10=1, press, not extended), `err` stays 0.
- Bytes F0,1C → `ps2_key`[10] toggles back to 0, `ps2_key`=11'h01C. No change on the F0 frame itself.
- Bytes E0,75 then E0,F0,75 → 11'h775, then 11'h175. The `ext` flag is cleared afterwards: a following 16 gives 11'h616 (bit10=1).
- Byte 1C sent with wrong parity (1) → single-cycle `err`, `ps2_key` unchanged. A next valid 1C produces a toggle.
- Byte 1C with stop bit 0, and separately a frame stalled after 4 bits for `TIMEOUT`+10 cycles → one `err` pulse each, no event. The next valid frame decodes correctly.
- Pause sequence E1,14,77,E1,F0,14,F0,77 → no events. A following 29 gives code 8'h29 with press=1.
- 1-cycle glitches injected on `ps2_clk` mid-frame with `FILTER`=8 → byte decoded unchanged, no `err`.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Turns the raw PS/2 keyboard clock/data lines into an 11-bit event word
//   for the keyboard-matrix block. Both lines are synchronised and the clock
//   is deglitched. 11-bit frames are deserialised, and their parity and stop
//   bits are checked. The E0/F0/E1 prefixes are folded into one event per key.
//
//   Ports:
//     clk_sys   in   system clock (only clock)
//     reset     in   synchronous active-high reset
//     ps2_clk   in   raw PS/2 clock (asynchronous)
//     ps2_data  in   raw PS/2 data (asynchronous)
//     ps2_key   out  [10] toggle per event, [9] press, [8] extended, [7:0] code
//     err       out  one-cycle pulse per rejected or timed-out frame
module ps2_key_decoder #(
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        err
);

    localparam int unsigned FW = $clog2(FILTER + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t          r_state, w_next;
    logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic [FW-1:0]   r_fcnt;
    logic            r_fclk;
    logic [TW-1:0]   r_tcnt;
    logic [7:0]      r_shift;
    logic [2:0]      r_bitcnt;
    logic            r_par;
    logic            r_ext, r_rel;
    logic [2:0]      r_skip;
    logic [10:0]     r_key;
    logic            r_err;

    logic            w_fall, w_timeout, w_par_ok;
    logic            w_shift_en, w_par_en, w_byte_valid, w_frame_err;

    // Two-stage synchronisers; idle level of both lines is high.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // The filtered clock flips only after FILTER consecutive samples that
    // disagree with it. Any agreeing sample restarts the run.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_fcnt <= '0;
            r_fclk <= 1'b1;
        end else if (r_clk_s2 == r_fclk) begin
            r_fcnt <= '0;
        end else if (r_fcnt == FW'(FILTER - 1)) begin
            r_fcnt <= '0;
            r_fclk <= r_clk_s2;
        end else begin
            r_fcnt <= r_fcnt + FW'(1);
        end
    end

    // Asserted on the same cycle that fclk is about to go 1->0, so data is
    // taken from the synchronised line alongside it.
    assign w_fall = r_fclk & ~r_clk_s2 & (r_fcnt == FW'(FILTER - 1));

    // Inter-edge watchdog, only armed while a frame is in progress.
    always_ff @(posedge clk_sys) begin
        if (reset || r_state == S_IDLE || w_fall)
            r_tcnt <= '0;
        else
            r_tcnt <= r_tcnt + TW'(1);
    end

    assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_tcnt == TW'(TIMEOUT - 1));
    assign w_par_ok  = ^{r_shift, r_par};

    // State register.
    always_ff @(posedge clk_sys) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = S_IDLE;
        end else if (w_fall) begin
            unique case (r_state)
                S_IDLE:   if (!r_dat_s2) w_next = S_DATA;
                S_DATA:   if (r_bitcnt == 3'd7) w_next = S_PARITY;
                S_PARITY: w_next = S_STOP;
                S_STOP:   w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Output / control decode.
    always_comb begin
        w_shift_en   = 1'b0;
        w_par_en     = 1'b0;
        w_byte_valid = 1'b0;
        w_frame_err  = 1'b0;
        if (w_fall) begin
            unique case (r_state)
                S_DATA:   w_shift_en = 1'b1;
                S_PARITY: w_par_en   = 1'b1;
                S_STOP: begin
                    w_byte_valid = r_dat_s2 & w_par_ok;
                    w_frame_err  = ~(r_dat_s2 & w_par_ok);
                end
                default: ;
            endcase
        end
    end

    // Frame datapath: LSB-first shift, bit counter, parity capture.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_par    <= 1'b0;
        end else begin
            if (r_state == S_IDLE)
                r_bitcnt <= '0;
            if (w_shift_en) begin
                r_shift  <= {r_dat_s2, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (w_par_en)
                r_par <= r_dat_s2;
        end
    end

    // Byte handler. E1 arms a skip of the remaining seven Pause bytes.
    // Every error path also clears the prefix state.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_key  <= '0;
            r_err  <= 1'b0;
            r_ext  <= 1'b0;
            r_rel  <= 1'b0;
            r_skip <= '0;
        end else begin
            r_err <= w_frame_err | w_timeout;
            if (w_frame_err || w_timeout) begin
                r_ext  <= 1'b0;
                r_rel  <= 1'b0;
                r_skip <= '0;
            end else if (w_byte_valid) begin
                if (r_skip != 3'd0) begin
                    r_skip <= r_skip - 3'd1;
                end else begin
                    unique case (r_shift)
                        8'hE1: r_skip <= 3'd7;
                        8'hE0: r_ext  <= 1'b1;
                        8'hF0: r_rel  <= 1'b1;
                        default: begin
                            r_key <= {~r_key[10], ~r_rel, r_ext, r_shift};
                            r_ext <= 1'b0;
                            r_rel <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign ps2_key = r_key;
    assign err     = r_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
//   Directed bench for ps2_key_decoder. It bit-bangs PS/2 frames on the raw
//   lines and checks the event word and the err pulse count against
//   hand-computed values.
module tb_ps2_key_decoder;

    localparam int unsigned HALF    = 20;
    localparam int unsigned TMO     = 200;
    localparam logic [7:0]  PAUSE_SEQ [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1,
                                              8'hF0, 8'h14, 8'hF0, 8'h77};

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int err_cycles = 0;

    ps2_key_decoder #(.FILTER(8), .TIMEOUT(TMO)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .ps2_key (ps2_key),
        .err     (err)
    );

    always #5 clk_sys = ~clk_sys;

    // Counting high cycles makes a stretched pulse show up as an extra count.
    always @(negedge clk_sys) if (err === 1'b1) err_cycles++;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // One bit: data set during the high phase, then one clock low phase.
    // A glitch is a one-cycle pulse of the opposite level mid-phase.
    task automatic send_bit(input logic b, input logic glitch);
        ps2_data = b;
        if (glitch) begin
            cyc(HALF / 2); ps2_clk = 1'b0; cyc(1); ps2_clk = 1'b1; cyc(HALF - HALF / 2 - 1);
        end else begin
            cyc(HALF);
        end
        ps2_clk = 1'b0;
        if (glitch) begin
            cyc(HALF / 2); ps2_clk = 1'b1; cyc(1); ps2_clk = 1'b0; cyc(HALF - HALF / 2 - 1);
        end else begin
            cyc(HALF);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par,
                              input logic stop_bit, input logic glitch);
        logic [10:0] bits;
        bits = {stop_bit, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(bits[i], glitch);
        ps2_data = 1'b1;
        cyc(30);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cyc(5);
        reset = 1'b0;
        cyc(5);
        checks++;
        if (ps2_key !== 11'h000) begin
            failures++;
            $display("FAIL reset_key: got %h expected %h", ps2_key, 11'h000);
        end
        checks++;
        if (err !== 1'b0 || err_cycles != 0) begin
            failures++;
            $display("FAIL reset_err: got err=%b cycles=%0d expected 0/0", err, err_cycles);
        end
    endtask

    task automatic test_press;
        send_byte(8'h1C);
        checks++;
        if (ps2_key !== 11'h61C) begin
            failures++;
            $display("FAIL press_1C: got %h expected %h", ps2_key, 11'h61C);
        end
        checks++;
        if (err_cycles != 0) begin
            failures++;
            $display("FAIL press_err: got %0d err cycles expected 0", err_cycles);
        end
    endtask

    task automatic test_release;
        send_byte(8'hF0);
        checks++;
        if (ps2_key !== 11'h61C) begin
            failures++;
            $display("FAIL prefix_f0_hold: got %h expected %h", ps2_key, 11'h61C);
        end
        send_byte(8'h1C);
        checks++;
        if (ps2_key !== 11'h01C) begin
            failures++;
            $display("FAIL release_1C: got %h expected %h", ps2_key, 11'h01C);
        end
    endtask

    task automatic test_extended;
        send_byte(8'hE0);
        checks++;
        if (ps2_key !== 11'h01C) begin
            failures++;
            $display("FAIL prefix_e0_hold: got %h expected %h", ps2_key, 11'h01C);
        end
        send_byte(8'h75);
        checks++;
        if (ps2_key !== 11'h775) begin
            failures++;
            $display("FAIL ext_press_75: got %h expected %h", ps2_key, 11'h775);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        checks++;
        if (ps2_key !== 11'h175) begin
            failures++;
            $display("FAIL ext_release_75: got %h expected %h", ps2_key, 11'h175);
        end
        send_byte(8'h16);
        checks++;
        if (ps2_key !== 11'h616) begin
            failures++;
            $display("FAIL ext_cleared_16: got %h expected %h", ps2_key, 11'h616);
        end
    endtask

    task automatic test_prefix_order;
        send_byte(8'hF0);
        send_byte(8'hE0);
        send_byte(8'h6B);
        checks++;
        if (ps2_key !== 11'h16B) begin
            failures++;
            $display("FAIL f0_e0_order: got %h expected %h", ps2_key, 11'h16B);
        end
        send_byte(8'h16);
        checks++;
        if (ps2_key !== 11'h616) begin
            failures++;
            $display("FAIL after_order_16: got %h expected %h", ps2_key, 11'h616);
        end
    endtask

    task automatic test_parity_error;
        int e0;
        e0 = err_cycles;
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        checks++;
        if (err_cycles != e0 + 1) begin
            failures++;
            $display("FAIL parity_err: got %0d err cycles expected %0d", err_cycles - e0, 1);
        end
        checks++;
        if (ps2_key !== 11'h616) begin
            failures++;
            $display("FAIL parity_key_hold: got %h expected %h", ps2_key, 11'h616);
        end
        send_byte(8'h1C);
        checks++;
        if (ps2_key !== 11'h21C) begin
            failures++;
            $display("FAIL after_parity_1C: got %h expected %h", ps2_key, 11'h21C);
        end
    endtask

    task automatic test_stop_error;
        int e0;
        e0 = err_cycles;
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        checks++;
        if (err_cycles != e0 + 1) begin
            failures++;
            $display("FAIL stop_err: got %0d err cycles expected %0d", err_cycles - e0, 1);
        end
        checks++;
        if (ps2_key !== 11'h21C) begin
            failures++;
            $display("FAIL stop_key_hold: got %h expected %h", ps2_key, 11'h21C);
        end
    endtask

    task automatic test_timeout;
        int e0;
        logic [7:0] b;
        e0 = err_cycles;
        b = 8'h1C;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i], 1'b0);
        cyc(TMO + 10);
        ps2_data = 1'b1;
        checks++;
        if (err_cycles != e0 + 1) begin
            failures++;
            $display("FAIL timeout_err: got %0d err cycles expected %0d", err_cycles - e0, 1);
        end
        checks++;
        if (ps2_key !== 11'h21C) begin
            failures++;
            $display("FAIL timeout_key_hold: got %h expected %h", ps2_key, 11'h21C);
        end
        send_byte(8'h1C);
        checks++;
        if (ps2_key !== 11'h61C) begin
            failures++;
            $display("FAIL after_timeout_1C: got %h expected %h", ps2_key, 11'h61C);
        end
    endtask

    task automatic test_pause;
        int e0;
        e0 = err_cycles;
        for (int i = 0; i < 8; i++) send_byte(PAUSE_SEQ[i]);
        checks++;
        if (ps2_key !== 11'h61C) begin
            failures++;
            $display("FAIL pause_no_event: got %h expected %h", ps2_key, 11'h61C);
        end
        send_byte(8'h29);
        checks++;
        if (ps2_key !== 11'h229) begin
            failures++;
            $display("FAIL after_pause_29: got %h expected %h", ps2_key, 11'h229);
        end
        checks++;
        if (err_cycles != e0) begin
            failures++;
            $display("FAIL pause_err: got %0d err cycles expected 0", err_cycles - e0);
        end
    endtask

    task automatic test_glitch;
        int e0;
        e0 = err_cycles;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        checks++;
        if (ps2_key !== 11'h65A) begin
            failures++;
            $display("FAIL glitch_5A: got %h expected %h", ps2_key, 11'h65A);
        end
        checks++;
        if (err_cycles != e0) begin
            failures++;
            $display("FAIL glitch_err: got %0d err cycles expected 0", err_cycles - e0);
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_extended();
        test_prefix_order();
        test_parity_error();
        test_stop_error();
        test_timeout();
        test_pause();
        test_glitch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
